// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot loader turning a host byte stream (count header + LSB-first words) into instruction-memory writes, core held until done.
// Write strobe is registered one cycle after each 4th byte; In_Ready stays high while loading. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [7:0]  In_Data,
    input  logic        In_Valid,
    output logic        In_Ready,
    output logic        Mem_WE,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic        Core_Hold,
    output logic        Load_Done,
    output logic        Load_Err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t              state;
    logic [15:0]         count;
    logic [ADDR_W-1:0]   idx;
    logic [1:0]          lane;
    logic [23:0]         wbuf;
    logic                last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`else
    logic                wr_last;
`endif

    assign last_word = (16'(idx) == count - 16'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            count     <= '0;
            idx       <= '0;
            lane      <= '0;
            wbuf      <= '0;
            In_Ready  <= 1'b0;
            Mem_WE    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_WData <= '0;
            Core_Hold <= 1'b1;
            Load_Done <= 1'b0;
            Load_Err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`else
            wr_last   <= 1'b0;
`endif
        end else begin
            Mem_WE <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (Start) begin
                        state     <= HDR0;
                        In_Ready  <= 1'b1;
                        Core_Hold <= 1'b1;
                        Load_Done <= 1'b0;
                        Load_Err  <= 1'b0;
                        idx       <= '0;
                        lane      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= '0;
`else
                        wr_last   <= 1'b0;
`endif
                    end
                end
                HDR0: begin
                    if (In_Valid) begin
                        count[7:0] <= In_Data;
                        state      <= HDR1;
                    end
                end
                HDR1: begin
                    if (In_Valid) begin
                        count[15:8] <= In_Data;
                        if ({1'b0, In_Data, count[7:0]} > CAP) begin
                            state    <= ERR;
                            In_Ready <= 1'b0;
                            Load_Err <= 1'b1;
                        end else if ({In_Data, count[7:0]} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= CSUM;
`else
                            state     <= DONE;
                            In_Ready  <= 1'b0;
                            Core_Hold <= 1'b0;
                            Load_Done <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
`ifndef LOADER_CHECKSUM_EN
                    // Final word's write cycle: stay in DATA so the strobe never lands in DONE.
                    if (wr_last) begin
                        wr_last   <= 1'b0;
                        state     <= DONE;
                        In_Ready  <= 1'b0;
                        Core_Hold <= 1'b0;
                        Load_Done <= 1'b1;
                    end else
`endif
                    if (In_Valid) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ In_Data;
`endif
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: wbuf[7:0]   <= In_Data;
                            2'd1: wbuf[15:8]  <= In_Data;
                            2'd2: wbuf[23:16] <= In_Data;
                            default: begin
                                Mem_WE    <= 1'b1;
                                Mem_Addr  <= 32'({idx, 2'b00});
                                Mem_WData <= {In_Data, wbuf};
                                idx       <= idx + ADDR_W'(1);
                                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                    state   <= CSUM;
`else
                                    wr_last <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (In_Valid) begin
                        In_Ready <= 1'b0;
                        if (In_Data == csum) begin
                            state     <= DONE;
                            Core_Hold <= 1'b0;
                            Load_Done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            Load_Err <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    In_Ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
